vga_sprite_layer: RTL

- Parametrised successor to the single-ball overlay. Composites NUM_SPRITES solid-colour rectangular sprites over a flat background colour and produces the 16-bit vga_data word for the colour-extend stage.
- Sprite attributes are double-buffered: software writes go to pending registers, and those are promoted to active registers at each frame start. The picture therefore never tears mid-frame.
- Adds a fixed 2-cycle pixel pipeline, lowest-index-wins priority, and a per-frame sprite-collision flag.

---
 rtl/vga_sprite_layer_if.sv | 13 +
 rtl/vga_sprite_layer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/vga_sprite_layer_if.sv
// vga_sprite_layer_if: sprite attribute write bus
interface vga_sprite_layer_if #(
  parameter int IDXW = 2
);
  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [9:0]      wr_x;
  logic [9:0]      wr_y;
  logic [15:0]     wr_color;
  logic            wr_vis;
  modport master(output wr_en, wr_idx, wr_x, wr_y, wr_color, wr_vis);
  modport slave(input wr_en, wr_idx, wr_x, wr_y, wr_color, wr_vis);
endinterface

// File: rtl/vga_sprite_layer.sv
// vga_sprite_layer: double-buffered sprite compositor with 2-cycle pixel pipeline and collision flag
module vga_sprite_layer #(
  parameter int          NUM_SPRITES = 4,
  parameter int          SPRITE_W    = 16,
  parameter int          SPRITE_H    = 16,
  parameter logic [15:0] BG_COLOR    = 16'h380F,
  localparam int         IDXW        = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            frame_start,
  input  logic [9:0]      vga_x,
  input  logic [9:0]      vga_y,
  input  logic            pix_valid,
  vga_sprite_layer_if.slave wr,
  output logic [15:0]     vga_data,
  output logic            pix_valid_out,
  output logic            hit_any,
  output logic [IDXW-1:0] hit_idx,
  output logic            collision
);
  logic [9:0]             pend_x [NUM_SPRITES];
  logic [9:0]             pend_y [NUM_SPRITES];
  logic [15:0]            pend_c [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] pend_v;
  logic [9:0]             act_x [NUM_SPRITES];
  logic [9:0]             act_y [NUM_SPRITES];
  logic [15:0]            act_c [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] act_v;
  logic [9:0]             eff_x [NUM_SPRITES];
  logic [9:0]             eff_y [NUM_SPRITES];
  logic [15:0]            eff_c [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] eff_v;
  logic [NUM_SPRITES-1:0] hit;
  logic [NUM_SPRITES-1:0] hit_q;
  logic [15:0]            col_q [NUM_SPRITES];
  logic                   pv_q;
  logic [IDXW-1:0]        win_idx;
  logic [15:0]            win_c;
  logic                   ovl;
  logic                   acc;

  // Software writes land in pending; frame_start copies pending (pre-write) into active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_v <= '0;
      act_v  <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pend_x[i] <= '0;
        pend_y[i] <= '0;
        pend_c[i] <= '0;
        act_x[i]  <= '0;
        act_y[i]  <= '0;
        act_c[i]  <= '0;
      end
    end else begin
      if (frame_start) begin
        act_v <= pend_v;
        for (int i = 0; i < NUM_SPRITES; i++) begin
          act_x[i] <= pend_x[i];
          act_y[i] <= pend_y[i];
          act_c[i] <= pend_c[i];
        end
      end
      if (wr.wr_en && 32'(wr.wr_idx) < 32'(NUM_SPRITES)) begin
        pend_x[wr.wr_idx] <= wr.wr_x;
        pend_y[wr.wr_idx] <= wr.wr_y;
        pend_c[wr.wr_idx] <= wr.wr_color;
        pend_v[wr.wr_idx] <= wr.wr_vis;
      end
    end
  end

  // Hit test in 11 bits so sprites clip at the edge; the frame_start sample already sees the promoted set.
  always_comb begin
    hit   = '0;
    eff_v = frame_start ? pend_v : act_v;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      eff_x[i] = frame_start ? pend_x[i] : act_x[i];
      eff_y[i] = frame_start ? pend_y[i] : act_y[i];
      eff_c[i] = frame_start ? pend_c[i] : act_c[i];
      hit[i] = eff_v[i] & pix_valid
             & ({1'b0, vga_x} >= {1'b0, eff_x[i]})
             & ({1'b0, vga_x} <= {1'b0, eff_x[i]} + 11'(SPRITE_W - 1))
             & ({1'b0, vga_y} >= {1'b0, eff_y[i]})
             & ({1'b0, vga_y} <= {1'b0, eff_y[i]} + 11'(SPRITE_H - 1));
    end
  end

  // Stage 1: hit vector, valid and the colours in force for this pixel travel together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q <= '0;
      pv_q  <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) col_q[i] <= '0;
    end else begin
      hit_q <= hit;
      pv_q  <= pix_valid;
      for (int i = 0; i < NUM_SPRITES; i++) col_q[i] <= eff_c[i];
    end
  end

  // Lowest set index wins; overlap means more than one bit set.
  always_comb begin
    win_idx = '0;
    win_c   = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      win_idx = hit_q[i] ? IDXW'(i) : win_idx;
      win_c   = hit_q[i] ? col_q[i] : win_c;
    end
    ovl = |(hit_q & (hit_q - NUM_SPRITES'(1)));
  end

  // Stage 2: composited output word and hit reporting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_data      <= '0;
      pix_valid_out <= 1'b0;
      hit_any       <= 1'b0;
      hit_idx       <= '0;
    end else begin
      vga_data      <= |hit_q ? win_c : pv_q ? BG_COLOR : 16'h0000;
      pix_valid_out <= pv_q;
      hit_any       <= |hit_q;
      hit_idx       <= win_idx;
    end
  end

  // Overlaps accumulate over a frame and are published at the next frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= 1'b0;
      collision <= 1'b0;
    end else if (frame_start) begin
      collision <= acc | ovl;
      acc       <= 1'b0;
    end else if (ovl) begin
      acc <= 1'b1;
    end
  end
endmodule
